// File: rtl/neural_link_tx_if.sv
// Link framer stream bundle: 64-bit packet input stream (from the async FIFO
// read port) and the 32-bit framed link output stream.
// master = the framer itself, slave = the surrounding environment.
interface neural_link_tx_if;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_sof;
   logic        tx_eof;

   modport master (
      input  in_data, in_valid, tx_ready,
      output in_ready, tx_data, tx_valid, tx_sof, tx_eof
   );

   modport slave (
      output in_data, in_valid, tx_ready,
      input  in_ready, tx_data, tx_valid, tx_sof, tx_eof
   );
endinterface

// File: rtl/neural_link_tx.sv
// neural_link_tx: downstream link framer.
// Packs up to MAX_PKTS 64-bit packets into a frame of 32-bit words:
//   header {SYNC_WORD, 8'h00, seq}, two payload words per packet (high half first),
//   trailer {8'h5A, packet count, CRC-16-CCITT over the payload words}.
// A partially filled frame is closed after TIMEOUT idle cycles waiting for a packet,
// or after the current packet when enable drops.
module neural_link_tx #(
   parameter int          MAX_PKTS  = 8,
   parameter int          TIMEOUT   = 64,
   parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
   input  logic               out_clk,
   input  logic               out_rst_n,
   input  logic               enable,
   neural_link_tx_if.master   link,
   output logic [15:0]        frame_cnt
);

   localparam int              TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR    = 3'd1,
      ST_PAY_HI = 3'd2,
      ST_PAY_LO = 3'd3,
      ST_TRL    = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [7:0]        seq_r;
   logic [7:0]        pkt_cnt_r;
   logic [TMR_W-1:0]  idle_tmr_r;
   logic [15:0]       frame_cnt_r;
   logic [15:0]       crc_r;
   logic [31:0]       lo_reg_r;

   logic              tx_valid_s;
   logic              tx_sof_s;
   logic              tx_eof_s;
   logic              in_ready_s;
   logic [31:0]       tx_data_s;
   logic              last_pkt_s;
   logic              tmr_expired_s;

   // CRC-16-CCITT (poly 0x1021), one 32-bit word, MSB first, no reflection.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] word);
      logic [15:0] c;
      logic        fb;
      c = crc_in;
      for (int i = 31; i >= 0; i--) begin
         fb = c[15] ^ word[i];
         c  = {c[14:0], 1'b0};
         if (fb) begin
            c = c ^ 16'h1021;
         end else begin
            c = c;
         end
      end
      return c;
   endfunction

   assign last_pkt_s    = (({1'b0, pkt_cnt_r} + 9'd1) == 9'(MAX_PKTS));
   assign tmr_expired_s = (idle_tmr_r == TMR_LAST) && (pkt_cnt_r != 8'd0);

   // Next-state decode and per-state link/handshake outputs.
   always_comb begin
      state_nxt_s = state_r;
      tx_valid_s  = 1'b0;
      tx_sof_s    = 1'b0;
      tx_eof_s    = 1'b0;
      in_ready_s  = 1'b0;
      tx_data_s   = 32'd0;
      case (state_r)
         ST_IDLE: begin
            if (enable && link.in_valid) begin
               state_nxt_s = ST_HDR;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HDR: begin
            tx_valid_s = 1'b1;
            tx_sof_s   = 1'b1;
            tx_data_s  = {SYNC_WORD, 8'h00, seq_r};
            if (link.tx_ready) begin
               state_nxt_s = ST_PAY_HI;
            end else begin
               state_nxt_s = ST_HDR;
            end
         end
         ST_PAY_HI: begin
            tx_valid_s = link.in_valid;
            tx_data_s  = link.in_data[63:32];
            in_ready_s = link.in_valid & link.tx_ready;
            // An arriving packet takes priority over the idle timeout.
            if (in_ready_s) begin
               state_nxt_s = ST_PAY_LO;
            end else if (tmr_expired_s) begin
               state_nxt_s = ST_TRL;
            end else begin
               state_nxt_s = ST_PAY_HI;
            end
         end
         ST_PAY_LO: begin
            tx_valid_s = 1'b1;
            tx_data_s  = lo_reg_r;
            if (link.tx_ready) begin
               if (last_pkt_s || !enable) begin
                  state_nxt_s = ST_TRL;
               end else begin
                  state_nxt_s = ST_PAY_HI;
               end
            end else begin
               state_nxt_s = ST_PAY_LO;
            end
         end
         ST_TRL: begin
            tx_valid_s = 1'b1;
            tx_eof_s   = 1'b1;
            tx_data_s  = {8'h5A, pkt_cnt_r, crc_r};
            if (link.tx_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_TRL;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Frame state register.
   always_ff @(posedge out_clk or negedge out_rst_n) begin
      if (!out_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Frame datapath: sequence, packet count, idle timer, CRC and low-half holding register.
   always_ff @(posedge out_clk or negedge out_rst_n) begin
      if (!out_rst_n) begin
         seq_r       <= 8'd0;
         pkt_cnt_r   <= 8'd0;
         idle_tmr_r  <= '0;
         frame_cnt_r <= 16'd0;
         crc_r       <= 16'hFFFF;
         lo_reg_r    <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               crc_r      <= 16'hFFFF;
               pkt_cnt_r  <= 8'd0;
               idle_tmr_r <= '0;
            end
            ST_HDR: begin
               if (link.tx_ready) begin
                  idle_tmr_r <= '0;
               end else begin
                  idle_tmr_r <= idle_tmr_r;
               end
            end
            ST_PAY_HI: begin
               if (in_ready_s) begin
                  lo_reg_r   <= link.in_data[31:0];
                  crc_r      <= crc16_word(crc_r, link.in_data[63:32]);
                  idle_tmr_r <= '0;
               end else if (idle_tmr_r != TMR_LAST) begin
                  idle_tmr_r <= idle_tmr_r + 1'b1;
               end else begin
                  idle_tmr_r <= idle_tmr_r;
               end
            end
            ST_PAY_LO: begin
               if (link.tx_ready) begin
                  pkt_cnt_r <= pkt_cnt_r + 8'd1;
                  crc_r     <= crc16_word(crc_r, lo_reg_r);
               end else begin
                  pkt_cnt_r <= pkt_cnt_r;
               end
            end
            ST_TRL: begin
               if (link.tx_ready) begin
                  seq_r       <= seq_r + 8'd1;
                  frame_cnt_r <= frame_cnt_r + 16'd1;
               end else begin
                  seq_r <= seq_r;
               end
            end
            default: begin
               seq_r <= seq_r;
            end
         endcase
      end
   end

   assign link.tx_valid = tx_valid_s;
   assign link.tx_sof   = tx_sof_s;
   assign link.tx_eof   = tx_eof_s;
   assign link.tx_data  = tx_data_s;
   assign link.in_ready = in_ready_s;
   assign frame_cnt     = frame_cnt_r;

endmodule
